// File: rtl/buzzer_melody_ctrl.sv
// buzzer_melody_ctrl: note-table melody sequencer with a pre-emptive key-beep arbiter
module buzzer_melody_ctrl #(
  parameter int TICK_DIV  = 50_000,
  parameter int GAP_MS    = 20,
  parameter int BEEP_FREQ = 2000,
  parameter int BEEP_MS   = 50
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_wr_en,
  input  logic [3:0]  i_wr_addr,
  input  logic [31:0] i_wr_freq,
  input  logic [15:0] i_wr_dur,
  input  logic [4:0]  i_length,
  input  logic        i_loop,
  input  logic        i_start,
  input  logic        i_stop,
  input  logic        i_beep,
  output logic [31:0] o_freqPWM,
  output logic        o_busy,
  output logic        o_beeping,
  output logic [3:0]  o_note_idx,
  output logic        o_done
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int BEEP_CYC = BEEP_MS * TICK_DIV;
  localparam int BW = BEEP_CYC > 1 ? $clog2(BEEP_CYC) : 1;
  typedef enum logic [1:0] {MIDLE, PLAY, GAP} mstate_t;
  typedef enum logic {BIDLE, BEEP} bstate_t;
  logic [31:0] freq_mem [16];
  logic [15:0] dur_mem [16];
  mstate_t state_q, state_d;
  bstate_t bstate_q, bstate_d;
  logic [3:0] idx_q, idx_d;
  logic [4:0] len_q, len_d;
  logic [31:0] cur_f_q, cur_f_d, freq_q, freq_d;
  logic [15:0] cur_dur_q, cur_dur_d, ms_q, ms_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic done_q, done_d;
  logic tick_end, play_end, gap_end, last_note, ld;
  always_ff @(posedge i_clk)
    if (i_wr_en) begin
      freq_mem[i_wr_addr] <= i_wr_freq;
      dur_mem[i_wr_addr]  <= i_wr_dur;
    end
  assign tick_end  = pre_q == PW'(TICK_DIV - 1);
  assign play_end  = state_q == PLAY && tick_end && ms_q == cur_dur_q - 16'd1;
  assign gap_end   = state_q == GAP && tick_end && ms_q == 16'(GAP_MS - 1);
  assign last_note = {1'b0, idx_q} >= len_q - 5'd1;
  // Melody timing only advances while no beep holds the output.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    len_d     = len_q;
    cur_f_d   = cur_f_q;
    cur_dur_d = cur_dur_q;
    pre_d     = pre_q;
    ms_d      = ms_q;
    done_d    = 1'b0;
    ld        = 1'b0;
    if (i_stop) begin
      state_d = MIDLE;
      idx_d   = '0;
      pre_d   = '0;
      ms_d    = '0;
    end else if (i_start && i_length != '0) begin
      state_d = PLAY;
      len_d   = i_length;
      idx_d   = '0;
      ld      = 1'b1;
      pre_d   = '0;
      ms_d    = '0;
    end else if (bstate_q == BIDLE && state_q != MIDLE) begin
      pre_d = tick_end ? '0 : pre_q + 1'b1;
      ms_d  = tick_end ? ms_q + 16'd1 : ms_q;
      if (play_end && GAP_MS != 0) begin
        state_d = GAP;
        pre_d   = '0;
        ms_d    = '0;
      end else if (play_end || gap_end) begin
        pre_d   = '0;
        ms_d    = '0;
        state_d = !last_note || i_loop ? PLAY : MIDLE;
        idx_d   = !last_note ? idx_q + 4'd1 : i_loop ? 4'd0 : idx_q;
        ld      = !last_note || i_loop;
        done_d  = last_note && !i_loop;
      end
    end
    if (ld) begin
      cur_f_d   = freq_mem[idx_d];
      cur_dur_d = dur_mem[idx_d] == '0 ? 16'd1 : dur_mem[idx_d];
    end
  end
  always_comb begin
    bstate_d = i_beep ? BEEP
             : (bstate_q == BEEP && bcnt_q == BW'(BEEP_CYC - 1)) ? BIDLE : bstate_q;
    bcnt_d   = (i_beep || bstate_q == BIDLE) ? '0 : bcnt_q + 1'b1;
    freq_d   = bstate_d == BEEP ? 32'(BEEP_FREQ) : state_d == PLAY ? cur_f_d : '0;
  end
  always_ff @(posedge i_clk)
    if (i_reset) begin
      state_q   <= MIDLE;
      bstate_q  <= BIDLE;
      idx_q     <= '0;
      len_q     <= '0;
      cur_f_q   <= '0;
      cur_dur_q <= 16'd1;
      pre_q     <= '0;
      ms_q      <= '0;
      bcnt_q    <= '0;
      done_q    <= 1'b0;
      freq_q    <= '0;
    end else begin
      state_q   <= state_d;
      bstate_q  <= bstate_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      cur_f_q   <= cur_f_d;
      cur_dur_q <= cur_dur_d;
      pre_q     <= pre_d;
      ms_q      <= ms_d;
      bcnt_q    <= bcnt_d;
      done_q    <= done_d;
      freq_q    <= freq_d;
    end
  assign o_freqPWM  = freq_q;
  assign o_busy     = state_q != MIDLE;
  assign o_beeping  = bstate_q == BEEP;
  assign o_note_idx = idx_q;
  assign o_done     = done_q;
endmodule

// File: tb/tb_buzzer_melody_ctrl.sv
// tb_buzzer_melody_ctrl: directed checks of playback, looping, beep arbitration and edge cases
module tb_buzzer_melody_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr_en = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [31:0] wr_freq = '0;
  logic [15:0] wr_dur = '0;
  logic [4:0] length = '0;
  logic loop = 1'b0, start = 1'b0, stop = 1'b0, beep = 1'b0;
  logic [31:0] freq;
  logic busy, beeping, done;
  logic [3:0] idx;
  int checks = 0;
  int failures = 0;
  int n;
  always #5 clk = ~clk;
  buzzer_melody_ctrl #(.TICK_DIV(10), .GAP_MS(2), .BEEP_FREQ(2000), .BEEP_MS(2)) dut (
    .i_clk(clk), .i_reset(rst), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
    .i_wr_freq(wr_freq), .i_wr_dur(wr_dur), .i_length(length), .i_loop(loop),
    .i_start(start), .i_stop(stop), .i_beep(beep), .o_freqPWM(freq),
    .o_busy(busy), .o_beeping(beeping), .o_note_idx(idx), .o_done(done)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask
  task automatic run_len(input logic [31:0] v, output int cnt);
    cnt = 0;
    while (freq == v && cnt < 2000) begin
      cnt++;
      tick();
    end
  endtask
  task automatic wr(input logic [3:0] a, input logic [31:0] f, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_freq = f; wr_dur = d;
    tick();
    wr_en = 1'b0;
  endtask
  task automatic pulse(input logic s, input logic p, input logic b);
    start = s; stop = p; beep = b;
    tick();
    start = 1'b0; stop = 1'b0; beep = 1'b0;
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_freq"}, freq, 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_beeping"}, 32'(beeping), 0);
    chk({tag, "_idx"}, 32'(idx), 0);
    chk({tag, "_done"}, 32'(done), 0);
  endtask
  initial begin
    ticks(2);
    chk_idle("reset");
    rst = 1'b0;
    wr(0, 440, 3);
    wr(1, 0, 1);
    // basic playback
    length = 2;
    pulse(1, 0, 0);
    chk("p1_busy", 32'(busy), 1);
    run_len(440, n);
    chk("p1_note0_len", n, 30);
    ticks(19);
    chk("p1_gap0_idx", 32'(idx), 0);
    tick();
    chk("p1_note1_idx", 32'(idx), 1);
    ticks(10);
    ticks(19);
    chk("p1_predone", 32'(done), 0);
    chk("p1_prebusy", 32'(busy), 1);
    tick();
    chk("p1_done", 32'(done), 1);
    chk("p1_busy_fall", 32'(busy), 0);
    chk("p1_idx_kept", 32'(idx), 1);
    tick();
    chk("p1_done_once", 32'(done), 0);
    // looping with a table write to the current entry
    loop = 1'b1;
    pulse(1, 0, 0);
    run_len(440, n);
    chk("p2_note0_len", n, 30);
    ticks(50);
    chk("p2_loop_idx", 32'(idx), 0);
    chk("p2_loop_freq", freq, 440);
    wr(0, 880, 3);
    chk("p2_wr_no_effect", freq, 440);
    run_len(440, n);
    chk("p2_rest_len", n, 29);
    ticks(50);
    chk("p2_wr_applied", freq, 880);
    chk("p2_wr_idx", 32'(idx), 0);
    ticks(5);
    pulse(0, 1, 0);
    chk("p2_stop_freq", freq, 0);
    chk("p2_stop_busy", 32'(busy), 0);
    chk("p2_stop_done", 32'(done), 0);
    chk("p2_stop_idx", 32'(idx), 0);
    loop = 1'b0;
    wr(0, 440, 3);
    // beep pre-empting note 0
    pulse(1, 0, 0);
    ticks(11);
    pulse(0, 0, 1);
    chk("p3_beeping", 32'(beeping), 1);
    chk("p3_busy", 32'(busy), 1);
    run_len(2000, n);
    chk("p3_beep_len", n, 20);
    chk("p3_resume_freq", freq, 440);
    run_len(440, n);
    chk("p3_remain_len", n, 18);
    pulse(0, 1, 0);
    // beep in idle, then retrigger
    pulse(0, 0, 1);
    run_len(2000, n);
    chk("p4_idle_beep_len", n, 20);
    chk("p4_after_freq", freq, 0);
    chk("p4_after_beeping", 32'(beeping), 0);
    pulse(0, 0, 1);
    ticks(14);
    pulse(0, 0, 1);
    run_len(2000, n);
    chk("p4_retrig_total", 15 + n, 35);
    // edge cases
    length = 0;
    pulse(1, 0, 0);
    chk("p5_len0_busy", 32'(busy), 0);
    wr(0, 1000, 0);
    length = 1;
    pulse(1, 0, 0);
    run_len(1000, n);
    chk("p5_dur0_len", n, 10);
    ticks(19);
    chk("p5_dur0_predone", 32'(done), 0);
    tick();
    chk("p5_dur0_done", 32'(done), 1);
    wr(0, 440, 3);
    length = 2;
    pulse(1, 1, 0);
    chk("p5_startstop_busy", 32'(busy), 0);
    chk("p5_startstop_freq", freq, 0);
    pulse(1, 0, 1);
    chk("p5_sb_beeping", 32'(beeping), 1);
    chk("p5_sb_busy", 32'(busy), 1);
    run_len(2000, n);
    chk("p5_sb_beep_len", n, 20);
    run_len(440, n);
    chk("p5_sb_note_len", n, 30);
    // reset while beeping during a melody
    pulse(0, 0, 1);
    chk("p6_beeping", 32'(beeping), 1);
    rst = 1'b1;
    tick();
    chk_idle("p6_reset");
    rst = 1'b0;
    ticks(3);
    chk_idle("p6_after");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
